// File: rtl/keypad_scan_fifo_if.sv
// Consumer-side bundle of the keypad scanner: key FIFO head,
// pop handshake, status flags and interrupt.
interface keypad_scan_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_pop;
  logic [LW-1:0] fifo_level;
  logic          key_down;
  logic          overflow;
  logic          ovf_clr;
  logic          irq;

  modport master (
    output key_valid, key_code, fifo_level,
    output key_down, overflow, irq,
    input  key_pop, ovf_clr
  );

  modport slave (
    input  key_valid, key_code, fifo_level,
    input  key_down, overflow, irq,
    output key_pop, ovf_clr
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad row scanner with sweep debounce and a small
// FIFO of key-press events.
module keypad_scan_fifo #(
  parameter int ROW_CYCLES = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] row_oeb,
  keypad_scan_fifo_if.master kp
);
  localparam int CW = $clog2(ROW_CYCLES);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(ROW_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_NONE, S_KEY, S_MULTI
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] code;
  } res_t;

  localparam res_t R_NONE = '{kind: S_NONE, code: 4'h0};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [11:0]   masks_q, masks_d;
  res_t          prev_q, prev_d;
  res_t          stable_q, stable_d;
  logic [DW-1:0] dbc_q, dbc_d;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [3:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    head_q, head_d;
  logic          ovf_q, ovf_d;

  logic [3:0]  smp;
  logic [15:0] all16;
  logic [4:0]  nbits;
  logic [3:0]  hit;
  res_t        res;
  logic        push, pop, push_ok, drop;

  assign smp   = ~col_in;
  assign all16 = {smp, masks_q};

  // Row 3 is classified straight from the live sample.
  always_comb begin
    nbits = '0;
    hit   = '0;
    for (int i = 0; i < 16; i++) begin
      if (all16[i]) begin
        nbits = nbits + 5'd1;
        hit   = 4'(i);
      end
    end
    res = R_NONE;
    if (nbits == 5'd1) begin
      res = '{kind: S_KEY, code: hit};
    end else if (nbits != 5'd0) begin
      res = '{kind: S_MULTI, code: 4'h0};
    end
  end

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    row_d    = row_q;
    masks_d  = masks_q;
    prev_d   = prev_q;
    dbc_d    = dbc_q;
    stable_d = stable_q;
    push     = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      row_d = row_q + 2'd1;
      unique case (row_q)
        2'd0: masks_d[3:0]  = smp;
        2'd1: masks_d[7:4]  = smp;
        2'd2: masks_d[11:8] = smp;
        2'd3: begin
          prev_d = res;
          if (res == prev_q) begin
            dbc_d = (dbc_q == DMAX) ? dbc_q : dbc_q + DW'(1);
          end else begin
            dbc_d = DW'(1);
          end
          if (dbc_d == DMAX && res != stable_q) begin
            stable_d = res;
            push     = (res.kind == S_KEY);
          end
        end
      endcase
    end
  end

  always_comb begin
    pop     = kp.key_pop && (level_q != '0);
    push_ok = push && ((level_q != FULL) || pop);
    drop    = push && (level_q == FULL) && !pop;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (push_ok) begin
      mem_d[wp_q] = stable_d.code;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
    level_d = level_q + LW'(push_ok) - LW'(pop);
    head_d  = (level_d != '0) ? mem_d[rp_d] : head_q;
    ovf_d   = drop | (ovf_q & ~kp.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      row_q    <= '0;
      masks_q  <= '0;
      prev_q   <= R_NONE;
      stable_q <= R_NONE;
      dbc_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q     <= '0;
      rp_q     <= '0;
      level_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      masks_q  <= masks_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      dbc_q    <= dbc_d;
      mem_q    <= mem_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      level_q  <= level_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign row_out       = reset ? 4'hE : ~(4'b0001 << row_q);
  assign row_oeb       = {4{reset}};
  assign kp.key_valid  = (level_q != '0);
  assign kp.irq        = (level_q != '0);
  assign kp.key_code   = head_q;
  assign kp.fifo_level = level_q;
  assign kp.key_down   = (stable_q.kind == S_KEY);
  assign kp.overflow   = ovf_q;
endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Matrix scanner for the 4x4 hex keypad.
- Drives the four row lines active-low, one row at a time, and samples the four column lines.
- Debounces complete sweeps and converts each new key press into a 4-bit key index.
- Buffers press events in a small FIFO.
- Sits upstream of the Wishbone/LA register stage, which pops codes through a valid/pop handshake and forwards the IRQ.

Parameters:
- ROW_CYCLES, 1000: clk cycles each row is driven; the sample is taken on the last cycle; minimum 2.
- DEBOUNCE, 4: consecutive identical sweep results required before the result is accepted as stable; minimum 1.
- FIFO_DEPTH, 4: key-event FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock for all state.
- reset  in  1  synchronous, active-high reset.
- col_in  in  4  column lines, active-low (external pull-ups); bit c = column c.
- row_out  out  4  row drive, active-low; bit r = row r.
- row_oeb  out  4  pad output-enable, active-low.
- key_valid  out  1  FIFO non-empty; key_code is meaningful.
- key_code  out  4  FIFO head = {row[1:0], col[1:0]}.
- key_pop  in  1  consumer pop; acted on only when key_valid=1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries.
- key_down  out  1  debounced "exactly one key held".
- overflow  out  1  sticky: a press was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- irq  out  1  equals key_valid.

Behaviour:
Reset (synchronous, highest priority; all state cleared):
- row_out=4'hE, row_oeb=4'hF while reset=1 and 4'h0 afterwards.
- key_valid=0, key_code=0, fifo_level=0, key_down=0, overflow=0.
- Row index=0, cycle counter=0, debounce counter=0, stable state=NONE.

Scan:
- row_out = ~(1<<row).
- The cycle counter runs 0..ROW_CYCLES-1. At count ROW_CYCLES-1, sample ~col_in into a per-row 4-bit pressed mask, then advance row (3 wraps to 0) and clear the counter.
- One sweep = 4*ROW_CYCLES cycles.

Sweep result, evaluated on the cycle the row 3 sample is taken (the sampled row-3 mask is included):
- KEY(code): exactly one bit set across all 16.
- NONE: zero bits set.
- MULTI: two or more bits set.

Debounce:
- If the result equals the previous sweep result, increment the debounce counter (saturating at DEBOUNCE); otherwise set it to 1.
- When the counter reaches DEBOUNCE and the result differs from the stable state, the result becomes the new stable state on that cycle.
- key_down=1 iff the stable state is KEY.

Events:
- A stable-state change into KEY(k) from NONE, MULTI or KEY(j≠k) generates one push of k.
- A held key never repeats.
- Transitions to NONE or MULTI push nothing.

FIFO:
- A push is accepted if not full, or if a pop occurs in the same cycle.
- When full with no pop, the push is dropped and overflow is set.
- Pop: when key_pop && key_valid, the head advances on the next edge; key_pop while empty is ignored.
- Simultaneous push and pop: level is unchanged.
- Push into an empty FIFO: key_valid=1 and key_code valid on the cycle after the push edge (registered).
- key_code holds the last head value while empty.
- Priority: ovf_clr and an overflow-setting drop in the same cycle leave overflow=1.

Test Plan (ROW_CYCLES=4, DEBOUNCE=2, FIFO_DEPTH=4):
1. Reset release -> row_out steps E,D,B,7 every 4 cycles and wraps; row_oeb=0; key_valid=0, fifo_level=0.
2. Hold key row2/col1 (col_in[1]=0 while row_out[2]=0) for 3 sweeps -> exactly one push, key_code=4'h9, key_valid=1, key_down=1. Release -> key_down=0 after 2 NONE sweeps, no further push.
3. Press lasting exactly 1 sweep (bounce) -> no push, key_down stays 0.
4. Press keys 0x0,0x5,0xA,0xF,0x3 sequentially, each with a release between, and no pops -> fifo_level=4, overflow=1. Then pops return 0,5,A,F in order and key_valid drops after the 4th pop.
5. Keys 0x1 and 0x2 held together -> MULTI, no push. Release 0x2 leaving 0x1 held -> one push of 0x1.
6. key_pop asserted on the same cycle as a push while level=4 -> level stays 4, overflow unchanged. Assert reset mid-sweep with level=2 -> next cycle level=0, key_valid=0, row_out=4'hE.
